seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the 8-digit, active-low seven-segment display between three requesters: student ID, switch-count/key-count and decimal timer.
- Each requester presents 8 BCD nibbles with a request line.
- The block grants the display round-robin, with a minimum dwell per grant.
- It snapshots the granted data once per scan frame and performs the digit scan (led_en/led_cx).

Parameters:
- REFRESH_CNT, 200000, clock cycles each digit stays enabled (2 ms at 100 MHz); one frame = 8*REFRESH_CNT cycles.
- HOLD_FRAMES, 250, minimum frames a grant is held before rotating to another active requester (must be >=1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  3  req[i]=1: requester i wants the display
- data0  input  32  requester 0 digits; nibble k (bits 4k+3:4k) drives digit position k, k=0 rightmost
- data1  input  32  requester 1 digits, same layout
- data2  input  32  requester 2 digits, same layout
- grant  output  3  one-hot current owner; 000 = idle
- frame_done  output  1  one-cycle pulse at the start of every frame
- led_en  output  8  active-low digit enable, bit k = position k
- led_cx  output  8  active-low segments {a,b,c,d,e,f,g,dp}

Behaviour:
- Reset, synchronous, active-high; while rst is high at a clk edge:
  - all outputs are registered: led_en=8'hFF, led_cx=8'hFF, grant=000, frame_done=0
  - scan counter=0, pos=0, hold_cnt=0, rr pointer=2 (so requester 0 has first priority), snapshot=32'hFFFFFFFF, state=IDLE
  - reset mid-frame aborts the scan immediately
- Scan:
  - Counter runs 0..REFRESH_CNT-1; pos advances 0..7 and wraps on each counter terminal count.
  - led_en = ~(1<<pos) and led_cx = decode(snapshot nibble pos), both registered: they change one cycle after pos.
  - First cycle after reset release: led_en=8'hFE.
- Decode table (hex):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F, 8:01, 9:09
  - A–E: FD (dash)
  - F: FF (blank)
- Frame boundary: the cycle with counter==REFRESH_CNT-1 and pos==7. Arbitration, snapshot load and hold_cnt update happen only on this edge, so there is no tearing mid-frame. frame_done is high for the single cycle that follows.
- States:
  - IDLE: grant=000, snapshot all F. At a boundary, if any req is high, grant the first active requester scanning rr+1, rr+2, rr (mod 3), set rr to that index, hold_cnt=0, go to GRANTED.
  - GRANTED, owner o. At a boundary:
    - if req[o]=0: re-arbitrate among the others using the rr scan; none active -> IDLE.
    - else if hold_cnt==HOLD_FRAMES-1 and some other req is active: rotate to the next active requester after o, hold_cnt=0.
    - else: keep o; hold_cnt increments, saturating at HOLD_FRAMES-1.
- A requester dropping or raising req mid-frame has no effect until the next boundary.
- Snapshot at a boundary loads data of the new owner, or all F if the next state is IDLE. The granted data is therefore visible from the frame that starts right after the boundary.
- Data changes mid-frame are ignored until the next boundary.
- grant is updated on the boundary edge, i.e. it is valid in the same cycle frame_done is high.

Optional Feature:
- Macro SEG_ZERO_BLANK_EN.
- Defined: leading-zero suppression on the displayed value. For positions 7 down to 1, a nibble 0 is shown as blank (8'hFF) while every nibble above it is 0 or F. Position 0 always shows its digit. Suppression applies at decode; the snapshot is not altered.
- Undefined: every nibble is decoded literally.

Test Plan:
- Use REFRESH_CNT=4, HOLD_FRAMES=2 (frame = 32 cycles) for all benches.
- Reset: rst high 3 cycles -> led_en=FF, led_cx=FF, grant=000. Release, req=000 -> led_en steps FE, FD, FB, … every 4 cycles, led_cx stays FF, frame_done pulses every 32 cycles.
- Single grant: req=001, data0=32'h04083145 -> grant=001 at the first boundary. In the next frame pos0 shows 49 (5), pos1 99 (4), pos6 99 (4), pos7 03 (0).
- Round-robin: req=111 from IDLE -> grant 001 for 2 frames, then 010 for 2, then 100 for 2, then 001. With only req=010 active, grant 010 is held indefinitely.
- Mid-frame change: change data0 and drop req[0] in the middle of a frame (pos=3) -> current frame digits unchanged. At the boundary, grant moves to the next active requester, or 000 with led_cx FF if none.
- Reset mid-frame with grant=100 -> next cycle all outputs FF and grant=000. The first grant after release obeys rr pointer=2 (requester 0 first).
- SEG_ZERO_BLANK_EN defined, data0=32'h00000045 -> pos7..pos2 show FF, pos1 99, pos0 49. Undefined -> pos7..pos2 show 03.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares the 8-digit active-low seven-segment display
// between three BCD requesters. Round-robin grant with a minimum dwell of
// HOLD_FRAMES frames; arbitration and the data snapshot only change on the
// frame boundary, so a displayed frame never mixes two sources.
// Optional macro SEG_ZERO_BLANK_EN: leading-zero suppression at decode.
//
// state   | meaning
// IDLE    | no owner, display blank (snapshot all F)
// GRANTED | rr holds the owner index, its data is shown
module seg_display_arbiter #(
   parameter int REFRESH_CNT = 200000,
   parameter int HOLD_FRAMES = 250
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [2:0]  grant,
   output logic        frame_done,
   output logic [7:0]  led_en,
   output logic [7:0]  led_cx
);

   localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
   localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t      state, state_n;
   logic [CW-1:0] cnt;
   logic [2:0]  pos;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [1:0]  rr, rr_n;
   logic [31:0] snapshot, snap_n;
   logic [2:0]  grant_n;
   logic        boundary;
   logic [2:0]  others;
   logic [2:0]  p_all, p_oth;
   logic [3:0]  cur_nib;
   logic        disp_blank;

   // Returns {found, index} of the first set bit scanning p+1, p+2, p (mod 3).
   function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] o0, o1, o2;
      case (p)
         2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
         2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
         default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
      if (r[o0])      pick = {1'b1, o0};
      else if (r[o1]) pick = {1'b1, o1};
      else if (r[o2]) pick = {1'b1, o2};
      else            pick = 3'b000;
   endfunction

   function automatic logic [7:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 8'h03;
         4'h1: decode = 8'h9F;
         4'h2: decode = 8'h25;
         4'h3: decode = 8'h0D;
         4'h4: decode = 8'h99;
         4'h5: decode = 8'h49;
         4'h6: decode = 8'h41;
         4'h7: decode = 8'h1F;
         4'h8: decode = 8'h01;
         4'h9: decode = 8'h09;
         4'hF: decode = 8'hFF;
         default: decode = 8'hFD;
      endcase
   endfunction

   assign boundary = (cnt == CNT_LAST) && (pos == 3'd7);
   assign others   = req & ~(3'b001 << rr);
   assign p_all    = pick(req, rr);
   assign p_oth    = pick(others, rr);
   assign cur_nib  = snapshot[4*pos +: 4];

`ifdef SEG_ZERO_BLANK_EN
   logic [7:0] lz;

   // Mark positions 7..1 whose zero sits under only zeros or blanks.
   always_comb begin : zero_blank
      logic       above_ok;
      logic [3:0] nib;
      lz       = 8'h00;
      above_ok = 1'b1;
      nib      = 4'h0;
      for (int k = 7; k >= 1; k--) begin
         nib      = snapshot[4*k +: 4];
         lz[k]    = above_ok && (nib == 4'h0);
         above_ok = above_ok && ((nib == 4'h0) || (nib == 4'hF));
      end
   end

   assign disp_blank = lz[pos];
`else
   assign disp_blank = 1'b0;
`endif

   // Arbitration next state; everything only moves on the frame boundary.
   always_comb begin
      state_n = state;
      rr_n    = rr;
      hold_n  = hold_cnt;
      grant_n = grant;
      snap_n  = snapshot;
      if (boundary) begin
         case (state)
            IDLE: begin
               if (p_all[2]) begin
                  state_n = GRANTED;
                  rr_n    = p_all[1:0];
                  hold_n  = '0;
               end
            end
            default: begin
               if (!req[rr] || ((hold_cnt == HOLD_LAST) && p_oth[2])) begin
                  hold_n = '0;
                  if (p_oth[2]) rr_n    = p_oth[1:0];
                  else          state_n = IDLE;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_n = hold_cnt + HW'(1);
               end
            end
         endcase
         if (state_n == GRANTED) begin
            grant_n = 3'b001 << rr_n;
            case (rr_n)
               2'd0:    snap_n = data0;
               2'd1:    snap_n = data1;
               default: snap_n = data2;
            endcase
         end else begin
            grant_n = 3'b000;
            snap_n  = 32'hFFFF_FFFF;
         end
      end
   end

   // Arbitration state, grant and frame snapshot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr       <= 2'd2;
         hold_cnt <= '0;
         grant    <= 3'b000;
         snapshot <= 32'hFFFF_FFFF;
      end else begin
         state    <= state_n;
         rr       <= rr_n;
         hold_cnt <= hold_n;
         grant    <= grant_n;
         snapshot <= snap_n;
      end
   end

   // Digit scan: per-digit dwell counter, position, and registered drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         pos        <= 3'd0;
         frame_done <= 1'b0;
         led_en     <= 8'hFF;
         led_cx     <= 8'hFF;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            pos <= pos + 3'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         frame_done <= boundary;
         led_en     <= ~(8'h01 << pos);
         led_cx     <= disp_blank ? 8'hFF : decode(cur_nib);
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (REFRESH_CNT=4, HOLD_FRAMES=2).
// The stimulus process drives one frame at a time and queues the grant and
// digit pattern expected after the coming boundary; the monitor pops one
// entry per frame_done and checks grant plus all eight digits of that frame.
module tb_seg_display_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [31:0] data0, data1, data2;
   logic [2:0]  grant;
   logic        frame_done;
   logic [7:0]  led_en, led_cx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic [2:0]  grant;
      bit          chk;
      logic [63:0] cx;
   } exp_t;

   exp_t sb[$];
   bit   mon_busy = 1'b0;

   localparam logic [31:0] D0  = 32'h0408_3145;
   localparam logic [31:0] D0B = 32'h1234_5678;
   localparam logic [31:0] D1  = 32'h9876_FEDA;
   localparam logic [31:0] D2  = 32'h0000_0045;
   localparam logic [31:0] D2B = 32'h0F00_0007;

   localparam logic [63:0] CX_IDLE = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] CX_D0B  = 64'h9F25_0D99_4941_1F01;
   localparam logic [63:0] CX_D1   = 64'h0901_1F41_FFFD_FDFD;
`ifdef SEG_ZERO_BLANK_EN
   localparam logic [63:0] CX_D0   = 64'hFF99_0301_0D9F_9949;
   localparam logic [63:0] CX_D2   = 64'hFFFF_FFFF_FFFF_9949;
   localparam logic [63:0] CX_D2B  = 64'hFFFF_FFFF_FFFF_FF1F;
`else
   localparam logic [63:0] CX_D0   = 64'h0399_0301_0D9F_9949;
   localparam logic [63:0] CX_D2   = 64'h0303_0303_0303_9949;
   localparam logic [63:0] CX_D2B  = 64'h03FF_0303_0303_031F;
`endif

   seg_display_arbiter #(.REFRESH_CNT(4), .HOLD_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .data0      (data0),
      .data1      (data1),
      .data2      (data2),
      .grant      (grant),
      .frame_done (frame_done),
      .led_en     (led_en),
      .led_cx     (led_cx)
   );

   always #5 clk = ~clk;

   task automatic check8(input string name, input int id, input logic [7:0] act,
                         input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (frame %0d): got %h expected %h", name, id, act, exp);
      end
   endtask

   // Drive one frame's inputs, queue what must follow its closing boundary.
   task automatic run_frame(input int id, input logic [2:0] r, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [2:0] eg, input bit chk, input logic [63:0] cx,
                            input bit mid = 1'b0, input logic [2:0] mr = 3'b000,
                            input logic [31:0] md0 = 32'h0, input bit post_rst = 1'b0);
      exp_t e;
      req   = r;
      data0 = d0;
      data1 = d1;
      data2 = d2;
      e.id = id; e.grant = eg; e.chk = chk; e.cx = cx;
      sb.push_back(e);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (post_rst && c == 0) check8("led_en_after_release", id, led_en, 8'hFE);
         if (mid && c == 12) begin
            req   = mr;
            data0 = md0;
         end
      end
   endtask

   // Monitor: one scoreboard entry per frame_done pulse.
   initial begin : monitor
      exp_t e;
      int   idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (frame_done) begin
            idle = 0;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame_done: got pulse expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               mon_busy = 1'b1;
               check8("grant", e.id, {5'b0, grant}, {5'b0, e.grant});
               if (e.chk) begin
                  for (int k = 0; k < 8; k++) begin
                     repeat ((k == 0) ? 1 : 4) @(negedge clk);
                     check8("led_en", e.id, led_en, ~(8'h01 << k));
                     check8("led_cx", e.id, led_cx, e.cx[8*k +: 8]);
                     check8("frame_done_low", e.id, {7'b0, frame_done}, 8'h00);
                  end
               end
               mon_busy = 1'b0;
            end
         end else if (sb.size() != 0) begin
            idle++;
            if (idle > 40) begin
               e = sb.pop_front();
               checks++;
               errors++;
               $display("FAIL frame_done_timeout (frame %0d): got no pulse expected one", e.id);
               idle = 0;
            end
         end else begin
            idle = 0;
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; req = 3'b000; data0 = '0; data1 = '0; data2 = '0;
      repeat (3) @(negedge clk);
      check8("rst_led_en", 0, led_en, 8'hFF);
      check8("rst_led_cx", 0, led_cx, 8'hFF);
      check8("rst_grant", 0, {5'b0, grant}, 8'h00);
      check8("rst_frame_done", 0, {7'b0, frame_done}, 8'h00);
      rst = 1'b0;

      run_frame(1,  3'b000, D0, D1, D2, 3'b000, 1'b1, CX_IDLE, 1'b0, 3'b000, 32'h0, 1'b1);
      run_frame(2,  3'b001, D0, D1, D2, 3'b001, 1'b1, CX_D0);
      run_frame(3,  3'b001, D0, D1, D2, 3'b001, 1'b1, CX_D0);
      run_frame(4,  3'b111, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(5,  3'b111, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(6,  3'b111, D0, D1, D2, 3'b100, 1'b1, CX_D2);
      run_frame(7,  3'b111, D0, D1, D2, 3'b100, 1'b1, CX_D2);
      run_frame(8,  3'b111, D0, D1, D2, 3'b001, 1'b1, CX_D0);
      run_frame(9,  3'b010, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(10, 3'b010, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(11, 3'b010, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(12, 3'b010, D0, D1, D2, 3'b010, 1'b1, CX_D1);
      run_frame(13, 3'b110, D0, D1, D2, 3'b100, 1'b1, CX_D2);
      run_frame(14, 3'b001, D0, D1, D2, 3'b001, 1'b1, CX_D0);
      // mid-frame: data0 changes and req[0] drops while D0 is on display
      run_frame(15, 3'b001, D0, D1, D2, 3'b010, 1'b1, CX_D1, 1'b1, 3'b010, D0B);
      run_frame(16, 3'b010, D0B, D1, D2, 3'b000, 1'b1, CX_IDLE, 1'b1, 3'b000, D0B);
      run_frame(17, 3'b001, D0B, D1, D2, 3'b001, 1'b1, CX_D0B);
      run_frame(18, 3'b100, D0B, D1, D2, 3'b100, 1'b0, CX_IDLE);

      // reset in the middle of a frame owned by requester 2
      repeat (16) @(negedge clk);
      check8("pre_rst_grant", 18, {5'b0, grant}, 8'h04);
      rst = 1'b1;
      @(negedge clk);
      check8("midrst_led_en", 18, led_en, 8'hFF);
      check8("midrst_led_cx", 18, led_cx, 8'hFF);
      check8("midrst_grant", 18, {5'b0, grant}, 8'h00);
      check8("midrst_frame_done", 18, {7'b0, frame_done}, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_frame(19, 3'b011, D0B, D1, D2, 3'b001, 1'b1, CX_D0B, 1'b0, 3'b000, 32'h0, 1'b1);
      run_frame(20, 3'b000, D0B, D1, D2, 3'b000, 1'b1, CX_IDLE);
      run_frame(21, 3'b100, D0B, D1, D2B, 3'b100, 1'b1, CX_D2B);
      run_frame(22, 3'b100, D0B, D1, D2, 3'b100, 1'b1, CX_D2);
      run_frame(23, 3'b000, D0B, D1, D2, 3'b000, 1'b1, CX_IDLE);

      req = 3'b000;
      for (int i = 0; i < 200 && (sb.size() != 0 || mon_busy); i++) @(negedge clk);
      if (sb.size() != 0 || mon_busy) begin
         errors++;
         $display("FAIL drain_timeout: got %0d entries pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish expected finish by 100us");
      $fatal(1, "watchdog expired");
   end

endmodule
